// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit_pkg
// Brief    : Op encodings and FSM state type for the HI/LO multiply/divide unit.
// Revision : 1.0
// ============================================================================
package mult_div_unit_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage : mult_div_unit_pkg
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module   : mdu_step
// Brief    : One combinational iteration: right shift-add multiply or
//            left shift restoring-subtract divide on the {acc, q} pair.
// Revision : 1.0
// ============================================================================
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] operand,
    input  logic             div_mode,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, operand};
        rem      = {acc, q[WIDTH-1]};
        diff     = rem - {1'b0, operand};
        acc_next = acc;
        q_next   = q;
        if (div_mode) begin
            // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
            if (!diff[WIDTH]) begin
                acc_next = diff[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end else if (q[0]) begin
            {acc_next, q_next} = {sum, q[WIDTH-1:1]};
        end else begin
            {acc_next, q_next} = {1'b0, acc, q[WIDTH-1:1]};
        end
    end

endmodule : mdu_step
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
// Revision : 1.0
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            state, state_next;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  acc, q, opnd, a_raw;
    logic              is_div, neg_q, neg_r, div0;
    logic [WIDTH-1:0]  acc_next, q_next;

    logic              signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0]  res_hi, res_lo;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .q        (q),
        .operand  (opnd),
        .div_mode (is_div),
        .acc_next (acc_next),
        .q_next   (q_next)
    );

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start && !op[2]) state_next = S_CALC;
            S_CALC:  if (count == CW'(WIDTH-1)) state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op && a[WIDTH-1];
        b_neg     = signed_op && b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // Magnitude-domain result with sign restored; MIN/-1 wraps back to MIN naturally.
    always_comb begin
        prod_mag = {acc, q};
        prod     = neg_q ? -prod_mag : prod_mag;
        res_hi   = prod[2*WIDTH-1:WIDTH];
        res_lo   = prod[WIDTH-1:0];
        if (is_div) begin
            if (div0) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -acc : acc;
                res_lo = neg_q ? -q : q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            acc    <= '0;
            q      <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            acc    <= '0;
                            q      <= a_mag;
                            opnd   <= b_mag;
                            a_raw  <= a;
                            is_div <= op[1];
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            div0   <= (b == '0);
                            count  <= '0;
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                S_CALC: begin
                    acc   <= acc_next;
                    q     <= q_next;
                    count <= count + CW'(1);
                end
                S_FIN: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Self-checking bench for mult_div_unit against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} computed with plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, sq, sr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = 64'(sx * sy); return p; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; return p; end
            3'd2, 3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 3'd3) return {x % y, x / y};
                sq = sx / sy;
                sr = sx % sy;
                return {sr[31:0], sq[31:0]};
            end
            default: return {mhi, mlo};
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit interfere);
        logic [63:0] exp;
        int          n;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        if (o <= 3'd3) begin
            check("busy_after_issue", {63'd0, busy}, 64'd1);
            exp = model(o, x, y);
            n = 0;
            for (int i = 1; i <= 40; i++) begin
                if (interfere && i == 5) begin
                    start = 1'b1; op = 3'($urandom_range(0, 5));
                end
                if (i == 6) start = 1'b0;
                @(posedge clk); #1;
                if (interfere && i == 5) begin
                    check("hi_held_midop", {32'd0, hi}, {32'd0, mhi});
                    check("lo_held_midop", {32'd0, lo}, {32'd0, mlo});
                end
                if (done) begin n = i; break; end
            end
            check("latency", 64'(n), 64'd33);
            mhi = exp[63:32];
            mlo = exp[31:0];
            check("hi", {32'd0, hi}, {32'd0, mhi});
            check("lo", {32'd0, lo}, {32'd0, mlo});
            @(posedge clk); #1;
            check("done_one_cycle", {63'd0, done}, 64'd0);
            check("busy_cleared", {63'd0, busy}, 64'd0);
        end else begin
            if (o == 3'd4) mhi = x;
            if (o == 3'd5) mlo = x;
            check("hi_mt", {32'd0, hi}, {32'd0, mhi});
            check("lo_mt", {32'd0, lo}, {32'd0, mlo});
            check("busy_mt", {63'd0, busy}, 64'd0);
            check("done_mt", {63'd0, done}, 64'd0);
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        #12;
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op(3'd3, 32'd7, 32'd2, 1'b0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(3'd2, 32'd5, 32'd0, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'h0000_1234, 32'd0, 1'b0);
        run_op(3'd0, 32'h0001_0003, 32'hFFFF_0005, 1'b1);

        // Abort a divide mid-flight with an asynchronous reset.
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        mhi = '0; mlo = '0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            check("no_done_after_abort", {63'd0, done}, 64'd0);
            if (done) break;
        end
        run_op(3'd1, 32'd3, 32'd4, 1'b0);

        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 20)); end
                3: rb = 32'($urandom_range(0, 5)) - 32'd2;
                default: ;
            endcase
            run_op(ro, ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mult_div_unit
`default_nettype wire
